universal_register: RTL

//  Parametrised successor to the fixed 4-bit clock-enabled register bank: one WIDTH-bit register

---
 rtl/universal_register.sv | 116 +++++++++++
 1 files changed

// File: rtl/universal_register.sv
// Generic WIDTH-bit datapath register with a mode-selected next state
// (hold/load/shift/rotate/count), serial in/out, a wrap pulse and a terminal count.
module universal_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Clr,
    input  logic             Ce,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] Din,
    input  logic             SinL,
    input  logic             SinR,
    output logic [WIDTH-1:0] Q,
    output logic             Sout,
    output logic             Wrap,
    output logic             Tc
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_UP   = 3'b110;
    localparam logic [2:0] MODE_DOWN = 3'b111;

    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             wrap_q, wrap_d;
    logic             tc_s;

    // Next-state function: clear beats enable, enable gates every mode.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        wrap_d = wrap_q;
        if (Clr) begin
            q_d    = RESET_VAL;
            sout_d = 1'b0;
            wrap_d = 1'b0;
        end else if (Ce) begin
            wrap_d = 1'b0;
            case (Mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = Din;
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], SinR};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d    = {SinL, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_UP: begin
                    q_d    = q_q + ONE_VAL;
                    wrap_d = (q_q == ONES_VAL);
                end
                MODE_DOWN: begin
                    q_d    = q_q - ONE_VAL;
                    wrap_d = (q_q == ZERO_VAL);
                end
                default: q_d = q_q;
            endcase
        end else begin
            q_d    = q_q;
            sout_d = sout_q;
            wrap_d = wrap_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_q    <= RESET_VAL;
            sout_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count looks at the current mode only, deliberately ignoring Ce.
    always_comb begin
        tc_s = 1'b0;
        if (Mode == MODE_UP) begin
            tc_s = (q_q == ONES_VAL);
        end else if (Mode == MODE_DOWN) begin
            tc_s = (q_q == ZERO_VAL);
        end else begin
            tc_s = 1'b0;
        end
    end

    assign Q    = q_q;
    assign Sout = sout_q;
    assign Wrap = wrap_q;
    assign Tc   = tc_s;

endmodule
